// File: rtl/mem_access_scheduler.sv
// Memory access scheduler: arbitrates I-cache fills, D-cache fills and D-cache
// write-through stores onto one pipelined multi-cycle memory port.
module mem_access_scheduler #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr_req,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [ADDR_W-1:0] dcache_wr_data,
  output logic              dcache_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] icache_fill_data,
  output logic [ADDR_W-1:0] icache_fill_addr,
  output logic              icache_write_data_array,
  output logic              icache_write_tag_array,
  output logic              icache_busy,
  output logic [ADDR_W-1:0] dcache_fill_data,
  output logic [ADDR_W-1:0] dcache_fill_addr,
  output logic              dcache_write_data_array,
  output logic              dcache_write_tag_array,
  output logic              dcache_busy,
  output logic              stall_n
);

  localparam int CW  = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int OFF = $clog2(2 * WORDS_PER_BLOCK);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

  typedef enum logic [2:0] {IDLE, WRITE, FILL_I, FILL_D, DONE} state_t;
  // LAST_NONE (after reset) lets the I-cache win the first simultaneous-miss tie
  typedef enum logic [1:0] {LAST_NONE, LAST_I, LAST_D} last_t;

  state_t            state, state_nxt;
  last_t             last_fill;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     ic, rc;
  logic              filling, issuing, receiving, last_word;
  logic [ADDR_W-1:0] issue_addr, fill_addr;

  assign filling    = (state == FILL_I) || (state == FILL_D);
  assign issuing    = filling && (ic < CW'(WORDS_PER_BLOCK));
  assign receiving  = filling && mem_valid && (rc < CW'(WORDS_PER_BLOCK));
  assign last_word  = receiving && (rc == CW'(WORDS_PER_BLOCK - 1));
  assign issue_addr = base + {{(ADDR_W-CW-1){1'b0}}, ic, 1'b0};
  assign fill_addr  = base + {{(ADDR_W-CW-1){1'b0}}, rc, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_fill <= LAST_NONE;
      base      <= '0;
      ic        <= '0;
      rc        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == FILL_I) begin
        base <= icache_miss_addr & ~OFF_MASK;
        ic   <= '0;
        rc   <= '0;
      end else if (state == IDLE && state_nxt == FILL_D) begin
        base <= dcache_miss_addr & ~OFF_MASK;
        ic   <= '0;
        rc   <= '0;
      end else begin
        if (issuing)   ic <= ic + CW'(1);
        if (receiving) rc <= rc + CW'(1);
      end
      if (last_word) last_fill <= (state == FILL_I) ? LAST_I : LAST_D;
    end
  end

  always_comb begin
    state_nxt               = state;
    dcache_wr_ack           = 1'b0;
    mem_en                  = 1'b0;
    mem_wr                  = 1'b0;
    mem_addr                = '0;
    mem_wdata               = '0;
    icache_fill_data        = '0;
    icache_fill_addr        = '0;
    icache_write_data_array = 1'b0;
    icache_write_tag_array  = 1'b0;
    icache_busy             = 1'b0;
    dcache_fill_data        = '0;
    dcache_fill_addr        = '0;
    dcache_write_data_array = 1'b0;
    dcache_write_tag_array  = 1'b0;
    dcache_busy             = 1'b0;
    stall_n                 = 1'b0;

    case (state)
      IDLE: begin
        stall_n = !(icache_miss || dcache_miss || dcache_wr_req);
        if (dcache_wr_req)
          state_nxt = WRITE;
        else if (icache_miss && dcache_miss)
          state_nxt = (last_fill == LAST_I) ? FILL_D : FILL_I;
        else if (icache_miss)
          state_nxt = FILL_I;
        else if (dcache_miss)
          state_nxt = FILL_D;
      end
      WRITE: begin
        mem_en        = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = dcache_wr_addr;
        mem_wdata     = dcache_wr_data;
        dcache_wr_ack = 1'b1;
        state_nxt     = IDLE;
      end
      FILL_I, FILL_D: begin
        mem_en   = issuing;
        mem_addr = issuing ? issue_addr : '0;
        if (state == FILL_I) begin
          icache_busy             = 1'b1;
          icache_write_data_array = receiving;
          icache_write_tag_array  = last_word;
          icache_fill_data        = receiving ? mem_rdata : '0;
          icache_fill_addr        = receiving ? fill_addr : '0;
        end else begin
          dcache_busy             = 1'b1;
          dcache_write_data_array = receiving;
          dcache_write_tag_array  = last_word;
          dcache_fill_data        = receiving ? mem_rdata : '0;
          dcache_fill_addr        = receiving ? fill_addr : '0;
        end
        if (last_word) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Scoreboard bench for mem_access_scheduler: reactive cache models plus a
// fixed-latency (4-cycle) memory model.
module tb_mem_access_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_miss, dcache_miss, dcache_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic        dcache_wr_ack, mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] icache_fill_data, icache_fill_addr, dcache_fill_data, dcache_fill_addr;
  logic        icache_write_data_array, icache_write_tag_array, icache_busy;
  logic        dcache_write_data_array, dcache_write_tag_array, dcache_busy;
  logic        stall_n;
  logic        stray_valid = 1'b0;

  always #5 clk = ~clk;

  mem_access_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_ack(dcache_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .icache_fill_data(icache_fill_data), .icache_fill_addr(icache_fill_addr),
    .icache_write_data_array(icache_write_data_array),
    .icache_write_tag_array(icache_write_tag_array), .icache_busy(icache_busy),
    .dcache_fill_data(dcache_fill_data), .dcache_fill_addr(dcache_fill_addr),
    .dcache_write_data_array(dcache_write_data_array),
    .dcache_write_tag_array(dcache_write_tag_array), .dcache_busy(dcache_busy),
    .stall_n(stall_n)
  );

  function automatic logic [15:0] memData(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  // Memory: a read issued in cycle t returns in cycle t+4; not reset.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en && !mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_valid = pv[3] | stray_valid;
  assign mem_rdata = memData(pa[3]);

  typedef struct packed {
    logic        side;
    logic [15:0] addr;
    logic [15:0] data;
    logic        tag;
  } fill_t;

  fill_t       fill_q[$];
  logic [15:0] issue_q[$];
  logic [31:0] wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads_issued, stall_low, write_strobes;
  int i_busy_run = 0, d_busy_run = 0, last_i_busy_len = 0, last_d_busy_len = 0;
  int i_busy_rise = 0, d_busy_rise = 0, i_tag_cycle = 0, ack_cycle = 0;
  bit i_tag_seen = 0, d_tag_seen = 0, ack_seen = 0, keep_i = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic expectFill(input logic side, input logic [15:0] miss_addr);
    fill_t       e;
    logic [15:0] b;
    b = miss_addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      e.side = side;
      e.addr = b + 16'(2 * k);
      e.data = memData(e.addr);
      e.tag  = (k == 7);
      issue_q.push_back(e.addr);
      fill_q.push_back(e);
    end
  endtask

  task automatic handleFill(input logic side, input logic [15:0] addr,
                            input logic [15:0] data, input logic tag);
    fill_t e;
    write_strobes++;
    if (fill_q.size() == 0) begin
      checkOutput("fill_unexpected", 32'(fill_q.size()), 32'd1);
    end else begin
      e = fill_q.pop_front();
      checkOutput("fill_side", side, e.side);
      checkOutput("fill_addr", addr, e.addr);
      checkOutput("fill_data", data, e.data);
      checkOutput("fill_tag", tag, e.tag);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] w;
    cyc++;
    if (rst_n) begin
      if (!stall_n) stall_low++;
      if (mem_en && mem_wr) begin
        if (wr_q.size() == 0) checkOutput("wr_unexpected", 32'(wr_q.size()), 32'd1);
        else begin
          w = wr_q.pop_front();
          checkOutput("wr_addr", mem_addr, w[31:16]);
          checkOutput("wr_data", mem_wdata, w[15:0]);
          checkOutput("wr_ack", dcache_wr_ack, 1);
        end
      end else if (mem_en) begin
        reads_issued++;
        if (issue_q.size() == 0) checkOutput("rd_unexpected", 32'(issue_q.size()), 32'd1);
        else checkOutput("rd_addr", mem_addr, issue_q.pop_front());
      end
      if (dcache_wr_ack) begin ack_seen = 1; ack_cycle = cyc; end
      if (icache_write_data_array)
        handleFill(1'b0, icache_fill_addr, icache_fill_data, icache_write_tag_array);
      if (dcache_write_data_array)
        handleFill(1'b1, dcache_fill_addr, dcache_fill_data, dcache_write_tag_array);
      if (icache_write_tag_array) begin i_tag_seen = 1; i_tag_cycle = cyc; end
      if (dcache_write_tag_array) d_tag_seen = 1;
      if (icache_busy) begin
        if (i_busy_run == 0) i_busy_rise = cyc;
        i_busy_run++;
      end else if (i_busy_run > 0) begin
        last_i_busy_len = i_busy_run;
        i_busy_run = 0;
      end
      if (dcache_busy) begin
        if (d_busy_run == 0) d_busy_rise = cyc;
        d_busy_run++;
      end else if (d_busy_run > 0) begin
        last_d_busy_len = d_busy_run;
        d_busy_run = 0;
      end
    end
  end

  // One cycle of the cache models: drop levels once acked or tagged.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (ack_seen) begin dcache_wr_req = 0; ack_seen = 0; end
    if (i_tag_seen) begin
      if (keep_i) keep_i = 0;
      else icache_miss = 0;
      i_tag_seen = 0;
    end
    if (d_tag_seen) begin dcache_miss = 0; d_tag_seen = 0; end
  endtask

  task automatic applyStimulus(input logic i_req, input logic [15:0] i_addr,
                               input logic d_req, input logic [15:0] d_addr,
                               input logic w_req, input logic [15:0] w_addr,
                               input logic [15:0] w_data);
    if (i_req) begin icache_miss = 1; icache_miss_addr = i_addr; end
    if (d_req) begin dcache_miss = 1; dcache_miss_addr = d_addr; end
    if (w_req) begin
      dcache_wr_req = 1; dcache_wr_addr = w_addr; dcache_wr_data = w_data;
      wr_q.push_back({w_addr, w_data});
    end
  endtask

  task automatic runUntilQuiet(input string tag, input int max_cycles);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while (!(stall_n && !icache_miss && !dcache_miss && !dcache_wr_req &&
                 fill_q.size() == 0 && issue_q.size() == 0) && n < max_cycles);
    checkOutput({tag, "_completes"}, 32'(n < max_cycles), 32'd1);
  endtask

  task automatic doReset();
    icache_miss = 0; dcache_miss = 0; dcache_wr_req = 0;
    rst_n = 0;
    fill_q.delete(); issue_q.delete(); wr_q.delete();
    i_busy_run = 0; d_busy_run = 0;
    i_tag_seen = 0; d_tag_seen = 0; ack_seen = 0; keep_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 0;
    icache_miss = 0; dcache_miss = 0; dcache_wr_req = 0;
    icache_miss_addr = '0; dcache_miss_addr = '0;
    dcache_wr_addr = '0; dcache_wr_data = '0;
    #12;
    checkOutput("rst_stall_n", stall_n, 1);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_busy", {icache_busy, dcache_busy}, 0);
    checkOutput("rst_strobes", {icache_write_data_array, icache_write_tag_array,
                                dcache_write_data_array, dcache_write_tag_array,
                                dcache_wr_ack}, 0);
    doReset();

    // Single I-cache miss
    stepCycle();
    stall_low = 0; reads_issued = 0;
    applyStimulus(1, 16'h1236, 0, 16'h0, 0, 16'h0, 16'h0);
    expectFill(1'b0, 16'h1236);
    runUntilQuiet("t1", 40);
    checkOutput("t1_busy_len", last_i_busy_len, 12);
    checkOutput("t1_stall_cycles", stall_low, 14);
    checkOutput("t1_reads", reads_issued, 8);

    // Simultaneous misses right after reset: I first, then D
    doReset();
    stepCycle();
    applyStimulus(1, 16'h2002, 1, 16'h3008, 0, 16'h0, 16'h0);
    expectFill(1'b0, 16'h2002);
    expectFill(1'b1, 16'h3008);
    runUntilQuiet("t2", 80);
    checkOutput("t2_gap_tag_to_d_busy", d_busy_rise - i_tag_cycle, 3);
    checkOutput("t2_d_busy_len", last_d_busy_len, 12);

    // Store and I miss together: store wins, fill granted right after
    stepCycle();
    applyStimulus(1, 16'h5010, 0, 16'h0, 1, 16'h4000, 16'hBEEF);
    expectFill(1'b0, 16'h5010);
    runUntilQuiet("t3", 60);
    checkOutput("t3_ack_to_i_busy", i_busy_rise - ack_cycle, 2);

    // D fill, then both misses: I, then D despite I re-missing, then I again
    stepCycle();
    applyStimulus(0, 16'h0, 1, 16'h6000, 0, 16'h0, 16'h0);
    expectFill(1'b1, 16'h6000);
    runUntilQuiet("t4a", 40);
    stepCycle();
    keep_i = 1;
    applyStimulus(1, 16'h7000, 1, 16'h8000, 0, 16'h0, 16'h0);
    expectFill(1'b0, 16'h7000);
    expectFill(1'b1, 16'h8000);
    expectFill(1'b0, 16'h7000);
    runUntilQuiet("t4b", 120);

    // Reset on the 4th issue cycle, then stray mem_valid pulses
    stepCycle();
    applyStimulus(1, 16'h9000, 0, 16'h0, 0, 16'h0, 16'h0);
    expectFill(1'b0, 16'h9000);
    repeat (4) stepCycle();
    checkOutput("t5_issuing", {mem_en, icache_busy}, 2'b11);
    icache_miss = 0;
    rst_n = 0;
    #1;
    checkOutput("t5_rst_mem_en", mem_en, 0);
    checkOutput("t5_rst_addr", mem_addr, 0);
    checkOutput("t5_rst_busy", icache_busy, 0);
    checkOutput("t5_rst_stall_n", stall_n, 1);
    fill_q.delete(); issue_q.delete();
    i_busy_run = 0;
    @(posedge clk);
    #1 rst_n = 1;
    write_strobes = 0;
    repeat (6) stepCycle();
    for (int k = 0; k < 4; k++) begin
      stray_valid = 1;
      stepCycle();
      stray_valid = 0;
      stepCycle();
    end
    checkOutput("t5_stray_writes", write_strobes, 0);
    checkOutput("t5_idle_stall_n", stall_n, 1);

    // Fill at the top of the address space: no wrap to 0x0000
    stepCycle();
    applyStimulus(0, 16'h0, 1, 16'hFFFA, 0, 16'h0, 16'h0);
    expectFill(1'b1, 16'hFFFA);
    runUntilQuiet("t6", 40);

    checkOutput("end_fill_q", 32'(fill_q.size()), 0);
    checkOutput("end_wr_q", 32'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
